sobel_edge_stat: RTL and testbench

SOBEL_EDGE_STAT -- requirements
Module: sobel_edge_stat

---
 rtl/sobel_edge_stat_pkg.sv | 16 +
 rtl/sobel_edge_stat_sync_edge_det.sv | 39 +++
 rtl/sobel_edge_stat.sv | 177 +++++++++++++++++
 tb/tb_sobel_edge_stat.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_edge_stat_pkg.sv
// Shared definitions for the Sobel edge statistics block: FSM encoding,
// counter widths and the default binarization threshold.
package sobel_edge_stat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int COL_W     = 10;
    localparam int ROW_W     = 9;
    localparam int CNT_W     = 19;
    localparam int THR_DEF_P = 128;

endpackage

// File: rtl/sobel_edge_stat_sync_edge_det.sv
// Registered rise/fall detection for frame and line valid. Edges are suppressed
// in the first cycle after reset so a mid-frame release cannot fake a rise.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    input  logic hsync_i,
    output logic vsync_q_o,
    output logic hsync_q_o,
    output logic vs_rise_o,
    output logic vs_fall_o,
    output logic hs_rise_o,
    output logic hs_fall_o
);

    logic vs_q;
    logic hs_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vs_q    <= vsync_i;
            hs_q    <= hsync_i;
            armed_q <= 1'b1;
        end
    end

    assign vsync_q_o = vs_q;
    assign hsync_q_o = hs_q;
    assign vs_rise_o = armed_q &  vsync_i & ~vs_q;
    assign vs_fall_o = armed_q & ~vsync_i &  vs_q;
    assign hs_rise_o = armed_q &  hsync_i & ~hs_q;
    assign hs_fall_o = armed_q & ~hsync_i &  hs_q;

endmodule

// File: rtl/sobel_edge_stat.sv
// Binarizes Sobel gradient magnitudes and reports per-frame edge statistics.
// Bounding-box tracking is built only when SOBEL_EDGE_STAT_BBOX_EN is defined.
module sobel_edge_stat
    import sobel_edge_stat_pkg::*;
#(
    parameter int DW      = 8,
    parameter int IW      = 640,
    parameter int IH      = 480,
    parameter int THR_DEF = THR_DEF_P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vsync,
    input  logic             din_hsync,
    input  logic [DW-1:0]    din,
    input  logic             thr_sel,
    input  logic [DW-1:0]    thr,
    output logic             dout_vsync,
    output logic             dout_hsync,
    output logic [DW-1:0]    dout,
    output logic             stat_valid,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [COL_W-1:0] x_min,
    output logic [COL_W-1:0] x_max,
    output logic [ROW_W-1:0] y_min,
    output logic [ROW_W-1:0] y_max,
    output logic             bbox_valid,
    output logic             geom_err
);

    localparam logic [COL_W-1:0] IW_C    = COL_W'(IW);
    localparam logic [ROW_W-1:0] IH_C    = ROW_W'(IH);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic vs_rise, vs_fall, hs_rise, hs_fall;

    sync_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .vsync_i   (din_vsync),
        .hsync_i   (din_hsync),
        .vsync_q_o (dout_vsync),
        .hsync_q_o (dout_hsync),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hs_rise_o (hs_rise),
        .hs_fall_o (hs_fall)
    );

    state_e           state_q, state_d;
    logic [DW-1:0]    thr_q, thr_d, dout_q;
    logic [COL_W-1:0] col_q, col_d, col_base;
    logic [ROW_W-1:0] row_q, row_d, row_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, edge_cnt_q;
    logic             err_q, err_d, geom_err_q;
    logic             in_frame, pix, is_edge, frame_end;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vs_rise) state_d = ST_FRAME;
            ST_FRAME:  if (vs_fall) state_d = ST_REPORT;
            ST_REPORT: state_d = din_vsync ? ST_FRAME : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A rise seen in REPORT starts the next frame in the same cycle, so the
    // cleared counter values feed the accumulation directly.
    assign in_frame  = (state_q == ST_FRAME) || vs_rise;
    assign frame_end = (state_q == ST_FRAME) && vs_fall;
    assign pix       = in_frame && din_vsync && din_hsync;
    assign thr_d     = vs_rise ? (thr_sel ? thr : DW'(THR_DEF)) : thr_q;
    assign col_base  = (vs_rise || hs_rise) ? '0 : col_q;
    assign row_base  = vs_rise ? '0 : row_q;
    assign is_edge   = pix && (col_base != IW_C) && (row_base < IH_C) && (din >= thr_d);

    always_comb begin
        col_d = col_base;
        row_d = row_base;
        cnt_d = vs_rise ? '0 : cnt_q;
        err_d = vs_rise ? 1'b0 : err_q;
        if (pix) begin
            if (col_base == IW_C) err_d = 1'b1;
            else                  col_d = col_base + 1'b1;
        end
        if (is_edge && (cnt_d != CNT_MAX)) cnt_d = cnt_d + 1'b1;
        if (in_frame && hs_fall) begin
            if (col_base != IW_C)    err_d = 1'b1;
            if (row_base != ROW_MAX) row_d = row_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            thr_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            edge_cnt_q <= '0;
            geom_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dout_q  <= (din_hsync && (din >= thr_d)) ? '1 : '0;
            if (frame_end) begin
                edge_cnt_q <= cnt_d;
                geom_err_q <= err_d || (row_d != IH_C);
            end
        end
    end

    assign dout       = dout_q;
    assign stat_valid = (state_q == ST_REPORT);
    assign edge_cnt   = edge_cnt_q;
    assign geom_err   = geom_err_q;

`ifdef SOBEL_EDGE_STAT_BBOX_EN
    logic [COL_W-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d, x_min_q, x_max_q;
    logic [ROW_W-1:0] by_min_q, by_min_d, by_max_q, by_max_d, y_min_q, y_max_q;
    logic             seen_q, seen_d, bbox_valid_q;

    always_comb begin
        bx_min_d = vs_rise ? '0 : bx_min_q;
        bx_max_d = vs_rise ? '0 : bx_max_q;
        by_min_d = vs_rise ? '0 : by_min_q;
        by_max_d = vs_rise ? '0 : by_max_q;
        seen_d   = vs_rise ? 1'b0 : seen_q;
        if (is_edge) begin
            if (!seen_d || col_base < bx_min_d) bx_min_d = col_base;
            if (!seen_d || col_base > bx_max_d) bx_max_d = col_base;
            if (!seen_d || row_base < by_min_d) by_min_d = row_base;
            if (!seen_d || row_base > by_max_d) by_max_d = row_base;
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bx_min_q <= '0; bx_max_q <= '0; by_min_q <= '0; by_max_q <= '0;
            seen_q   <= 1'b0;
            x_min_q  <= '0; x_max_q  <= '0; y_min_q  <= '0; y_max_q  <= '0;
            bbox_valid_q <= 1'b0;
        end else begin
            bx_min_q <= bx_min_d; bx_max_q <= bx_max_d;
            by_min_q <= by_min_d; by_max_q <= by_max_d;
            seen_q   <= seen_d;
            if (frame_end) begin
                x_min_q <= bx_min_d; x_max_q <= bx_max_d;
                y_min_q <= by_min_d; y_max_q <= by_max_d;
                bbox_valid_q <= seen_d;
            end
        end
    end

    assign x_min      = x_min_q;
    assign x_max      = x_max_q;
    assign y_min      = y_min_q;
    assign y_max      = y_max_q;
    assign bbox_valid = bbox_valid_q;
`else
    assign x_min      = '0;
    assign x_max      = '0;
    assign y_min      = '0;
    assign y_max      = '0;
    assign bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_edge_stat.sv
// Scoreboard bench for sobel_edge_stat on an 8x4 image: per-cycle pixel output
// and per-frame statistics are predicted at drive time and checked on output.
module tb_sobel_edge_stat;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int THR_DEF = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_vsync = 1'b0;
    logic          din_hsync = 1'b0;
    logic [DW-1:0] din = '0;
    logic          thr_sel = 1'b0;
    logic [DW-1:0] thr = '0;
    logic          dout_vsync, dout_hsync, stat_valid, bbox_valid, geom_err;
    logic [DW-1:0] dout;
    logic [18:0]   edge_cnt;
    logic [9:0]    x_min, x_max;
    logic [8:0]    y_min, y_max;

    sobel_edge_stat #(.DW(DW), .IW(IW), .IH(IH), .THR_DEF(THR_DEF)) dut (
        .clk(clk), .rst(rst), .din_vsync(din_vsync), .din_hsync(din_hsync), .din(din),
        .thr_sel(thr_sel), .thr(thr), .dout_vsync(dout_vsync), .dout_hsync(dout_hsync),
        .dout(dout), .stat_valid(stat_valid), .edge_cnt(edge_cnt), .x_min(x_min),
        .x_max(x_max), .y_min(y_min), .y_max(y_max), .bbox_valid(bbox_valid),
        .geom_err(geom_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    typedef struct {
        int cnt, xmin, xmax, ymin, ymax, bv, err, cyc;
    } stat_t;

    logic [DW+1:0] exp_q[$];
    stat_t         stat_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] m_thr = '0;
    logic          m_prev_vs = 1'b0;
    logic [DW-1:0] pix_mem [0:15][0:15];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver: one input cycle, expected delayed pixel output queued
    task automatic drive(input logic r, input logic vs, input logic hs, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        rst = r; din_vsync = vs; din_hsync = hs; din = d;
        if (r) begin
            m_thr = '0;
            exp_q.push_back('0);
        end else begin
            if (vs && !m_prev_vs) m_thr = thr_sel ? thr : DW'(THR_DEF);
            exp_q.push_back({vs, hs, (hs && d >= m_thr) ? {DW{1'b1}} : {DW{1'b0}}});
        end
        m_prev_vs = vs;
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix_mem[r][c] = v;
    endtask

    // one frame: nl lines, first line len0 pixels, others len; thr_mid >= 0
    // changes the runtime threshold after the first line
    task automatic send_frame(input int pre, input int nl, input int len0, input int len,
                              input int thr_mid);
        stat_t s;
        int thr_e;
        int l;
        thr_e = thr_sel ? int'(thr) : THR_DEF;
        s.cnt = 0; s.xmin = 0; s.xmax = 0; s.ymin = 0; s.ymax = 0; s.bv = 0;
        s.err = (nl != IH) || (len0 != IW) || (nl > 1 && len != IW);
        for (int r = 0; r < nl; r++) begin
            l = (r == 0) ? len0 : len;
            for (int c = 0; c < l; c++) begin
                if (r < IH && c < IW && int'(pix_mem[r][c]) >= thr_e) begin
                    if (s.bv == 0) begin
                        s.xmin = c; s.xmax = c; s.ymin = r; s.ymax = r;
                    end else begin
                        if (c < s.xmin) s.xmin = c;
                        if (c > s.xmax) s.xmax = c;
                        if (r < s.ymin) s.ymin = r;
                        if (r > s.ymax) s.ymax = r;
                    end
                    s.bv = 1;
                    s.cnt++;
                end
            end
        end
`ifndef SOBEL_EDGE_STAT_BBOX_EN
        s.xmin = 0; s.xmax = 0; s.ymin = 0; s.ymax = 0; s.bv = 0;
`endif
        for (int i = 0; i < pre; i++) drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int r = 0; r < nl; r++) begin
            l = (r == 0) ? len0 : len;
            for (int c = 0; c < l; c++) drive(1'b0, 1'b1, 1'b1, pix_mem[r][c]);
            drive(1'b0, 1'b1, 1'b0, '0);
            drive(1'b0, 1'b1, 1'b0, '0);
            if (r == 0 && thr_mid >= 0) thr = DW'(thr_mid);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        s.cyc = cyc + 1;
        stat_q.push_back(s);
    endtask

    // monitor: sampled on the falling edge, away from input changes
    logic [DW+1:0] e;
    stat_t         so;
    always @(negedge clk) begin
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check_val("dout", 32'(dout), 32'(e[DW-1:0]));
            check_val("dout_hsync", 32'(dout_hsync), 32'(e[DW]));
            check_val("dout_vsync", 32'(dout_vsync), 32'(e[DW+1]));
        end
        if (stat_valid === 1'b1) begin
            if (stat_q.size() == 0) begin
                check_val("unexpected_stat_valid", 32'd1, 32'd0);
            end else begin
                so = stat_q.pop_front();
                check_val("stat_cycle", 32'(cyc), 32'(so.cyc));
                check_val("edge_cnt", 32'(edge_cnt), 32'(so.cnt));
                check_val("x_min", 32'(x_min), 32'(so.xmin));
                check_val("x_max", 32'(x_max), 32'(so.xmax));
                check_val("y_min", 32'(y_min), 32'(so.ymin));
                check_val("y_max", 32'(y_max), 32'(so.ymax));
                check_val("bbox_valid", 32'(bbox_valid), 32'(so.bv));
                check_val("geom_err", 32'(geom_err), 32'(so.err));
            end
        end
    end

    task automatic check_stats_zero(input string tag);
        @(negedge clk);
        check_val({tag, "_stat_valid"}, 32'(stat_valid), 32'd0);
        check_val({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd0);
        check_val({tag, "_bbox"}, 32'({x_min, x_max, y_min, y_max, bbox_valid}), 32'd0);
        check_val({tag, "_geom_err"}, 32'(geom_err), 32'd0);
        check_val({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, '0);
        check_stats_zero("reset");

        // full frame above default threshold
        thr_sel = 1'b0; fill(8'd200);
        send_frame(2, 4, 8, 8, -1);

        // single edge pixel exactly at threshold
        fill(8'd127); pix_mem[2][5] = 8'd128;
        send_frame(2, 4, 8, 8, -1);

        // all-zero frame, started back-to-back in the report cycle
        fill(8'd0);
        send_frame(0, 4, 8, 8, -1);

        // runtime threshold changed mid-frame, then used for the next frame
        thr_sel = 1'b1; thr = 8'd50; fill(8'd100);
        send_frame(2, 4, 8, 8, 250);
        send_frame(2, 4, 8, 8, -1);

        // overlong first line, then a short frame
        thr_sel = 1'b0; fill(8'd200);
        send_frame(2, 4, 9, 8, -1);
        send_frame(2, 3, 8, 8, -1);

        // random-content frame
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix_mem[r][c] = DW'($urandom_range(0, 255));
        send_frame(1, 4, 8, 8, -1);

        // reset during a frame: the aborted frame must not report
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 8; c++) drive(1'b0, 1'b1, 1'b1, 8'd200);
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_stats_zero("midframe_reset");
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1'b1, 8'd200);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0);
        fill(8'd150); pix_mem[0][0] = 8'd10; pix_mem[3][7] = 8'd10;
        send_frame(2, 4, 8, 8, -1);

        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_val("pending_reports", 32'(stat_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
